// File: rtl/uart_tx_queue_if.sv
// Byte-wide ready/valid port feeding the UART transmit queue.
// The master drives data/valid; the queue (slave) returns ready.
interface uart_tx_queue_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_queue.sv
// Buffered 8N1 UART transmitter: a small byte FIFO drained LSB-first onto a registered serial
// line, with frames sent back-to-back while bytes are queued.
module uart_tx_queue #(
  parameter int unsigned ClockFreq = 50_000_000,
  parameter int unsigned BaudRate  = 115_200,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_queue_if.slave             din,
  output logic                       sout,
  output logic                       busy,
  output logic [$clog2(FifoDepth):0] fifo_count
);

  localparam int unsigned BitPeriod = ClockFreq / BaudRate;
  localparam int unsigned CntW      = (BitPeriod > 1) ? $clog2(BitPeriod) : 1;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned CountW    = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]        mem_q [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              push, pop;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              sout_q, sout_d;
  logic              bit_end;
  logic              queued;

  assign din.ready = (count_q != CountW'(FifoDepth));
  assign push      = din.valid && din.ready;
  assign queued    = (count_q != '0);
  assign bit_end   = (cnt_q == CntW'(BitPeriod - 1));

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CountW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CountW'(1);
      end
    end
  end

  // The output bit for each phase is set up one edge early so sout_q holds it for the
  // whole bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    sout_d  = sout_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (queued) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          sout_d  = 1'b0;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          sout_d  = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            sout_d  = 1'b1;
            state_d = StStop;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            sout_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (queued) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            sout_d  = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      sout_q  <= sout_d;
    end
  end

  assign sout       = sout_q;
  assign busy       = (state_q != StIdle) || queued;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed vector table, corner sequences and random traffic,
// checked against a frame-timing model and a serial-line decoder.
module tb_uart_tx_queue;

  localparam int Depth    = 4;
  localparam int Bp       = 10;
  localparam int FrameLen = 10 * Bp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sout, busy;
  logic [2:0] fifo_count;

  uart_tx_queue_if txif ();

  uart_tx_queue #(
    .ClockFreq(1000),
    .BaudRate (100),
    .FifoDepth(Depth)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (txif),
    .sout      (sout),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks, n_fail, trk_bad, busy_fall;
  bit accepted, prev_busy;

  // Model: accept edges, expected frame start edges, bytes sent.
  int         acc_q[$], st_q[$], dut_acc_q[$];
  logic [7:0] sent_q[$];
  // Decoder output.
  logic [7:0] rx_b[$];
  int         rx_s[$];
  int         rx_bad[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_count(input int t);
    int c = 0;
    foreach (acc_q[i]) if (acc_q[i] <= t) c++;
    foreach (st_q[i]) if (st_q[i] <= t) c--;
    return c;
  endfunction

  function automatic bit m_frame(input int t);
    foreach (st_q[i]) if (st_q[i] <= t && t < st_q[i] + FrameLen) return 1'b1;
    return 1'b0;
  endfunction

  // Serial decoder: every bit must hold for Bp cycles; start 0, stop 1.
  initial begin : decoder
    int   ph, t0, slot;
    logic prev, val;
    logic [7:0] sh;
    int   err;
    ph = -1;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph = -1;
        prev = 1'b1;
      end else if (ph < 0) begin
        if (prev && !sout) begin
          ph = 0; t0 = cyc; err = 0; val = sout;
        end
        prev = sout;
      end else begin
        ph++;
        slot = ph / Bp;
        if (ph % Bp == 0) val = sout;
        else if (sout !== val) err = 1;
        if (slot >= 1 && slot <= 8 && ph % Bp == 0) sh[slot-1] = sout;
        if (slot == 9 && sout !== 1'b1) err = 1;
        if (ph == FrameLen - 1) begin
          rx_b.push_back(sh);
          rx_s.push_back(t0);
          rx_bad.push_back(err);
          ph = -1;
          prev = sout;
        end
      end
    end
  end

  task automatic clear_model();
    acc_q.delete(); st_q.delete(); dut_acc_q.delete(); sent_q.delete();
    rx_b.delete(); rx_s.delete(); rx_bad.delete();
  endtask

  // One cycle: decide acceptance from the model, step, then compare DUT against the model.
  task automatic tick();
    int c, ns;
    bit fr;
    c = m_count(cyc);
    accepted = 1'b0;
    if (txif.valid && txif.ready) dut_acc_q.push_back(cyc + 1);
    if (txif.valid && c != Depth) begin
      accepted = 1'b1;
      acc_q.push_back(cyc + 1);
      sent_q.push_back(txif.data);
      ns = cyc + 2;
      if (st_q.size() > 0 && st_q[st_q.size()-1] + FrameLen > ns) ns = st_q[st_q.size()-1] + FrameLen;
      st_q.push_back(ns);
    end
    @(negedge clk);
    c  = m_count(cyc);
    fr = m_frame(cyc);
    if (fifo_count !== 3'(c) || txif.ready !== (c != Depth) || busy !== (c != 0 || fr) ||
        (!fr && sout !== 1'b1)) begin
      trk_bad++;
      if (trk_bad <= 3)
        $display("track diff @%0d: count %0d/%0d ready %b busy %b sout %b",
                 cyc, fifo_count, c, txif.ready, busy, sout);
    end
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
  endtask

  task automatic idle(input int n);
    txif.valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    txif.data  = b;
    txif.valid = 1'b1;
    do begin
      tick();
      guard++;
    end while (!accepted && guard < 1000);
    check("push accepted", int'(accepted), 1);
  endtask

  task automatic drain();
    int guard = 0;
    txif.valid = 1'b0;
    do begin
      tick();
      guard++;
    end while ((busy || m_count(cyc) != 0 || m_frame(cyc)) && guard < 3000);
    check("drain idle", int'(busy), 0);
    repeat (3) tick();
  endtask

  task automatic check_rx(input string tag);
    check({tag, " frames"}, rx_b.size(), sent_q.size());
    for (int i = 0; i < rx_b.size() && i < sent_q.size(); i++) begin
      check({tag, " byte"}, int'(rx_b[i]), int'(sent_q[i]));
      check({tag, " start"}, rx_s[i], st_q[i]);
      check({tag, " shape"}, rx_bad[i], 0);
    end
    check({tag, " track"}, trk_bad, 0);
    trk_bad = 0;
    clear_model();
  endtask

  task automatic do_reset();
    txif.valid = 1'b0;
    txif.data  = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst sout", int'(sout), 1);
    check("rst ready", int'(txif.ready), 1);
    check("rst busy", int'(busy), 0);
    check("rst count", int'(fifo_count), 0);
    rst_n = 1'b1;
    clear_model();
    prev_busy = 1'b0;
    trk_bad = 0;
  endtask

  typedef struct {
    logic [7:0] data;
    int         start_lat;
    int         busy_lat;
  } vec_t;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[6];
    int   n, s, e;
    vecs[0] = '{8'h41, 1, 101};
    vecs[1] = '{8'h55, 1, 101};
    vecs[2] = '{8'h00, 1, 101};
    vecs[3] = '{8'hFF, 1, 101};
    vecs[4] = '{8'h80, 1, 101};
    vecs[5] = '{8'h01, 1, 101};

    // Reset values and a quiet line afterwards.
    do_reset();
    idle(200);
    check("idle sout", int'(sout), 1);
    check_rx("idle");

    // Single frames from an idle queue.
    foreach (vecs[k]) begin
      busy_fall = -1;
      push_byte(vecs[k].data);
      n = acc_q[0];
      drain();
      check("vec busy fall", busy_fall - n, vecs[k].busy_lat);
      check("vec start", (rx_s.size() > 0) ? rx_s[0] - n : -1, vecs[k].start_lat);
      check_rx("vec");
    end

    // Hold valid with six bytes: fill, stall, then contiguous frames.
    for (int k = 0; k < 6; k++) begin
      push_byte(8'(k + 1));
      if (k == 4) begin
        check("full count", int'(fifo_count), 4);
        check("full ready", int'(txif.ready), 0);
      end
    end
    check("burst accepts", dut_acc_q.size(), 6);
    if (dut_acc_q.size() == 6) begin
      for (int k = 1; k < 5; k++) check("burst edge", dut_acc_q[k] - dut_acc_q[0], k);
      check("6th edge", dut_acc_q[5] - dut_acc_q[0], 102);
    end
    drain();
    for (int k = 1; k < rx_s.size(); k++) check("contiguous", rx_s[k] - rx_s[0], FrameLen * k);
    check_rx("burst");

    // Reset in the middle of data bit 3 with a byte still queued.
    push_byte(8'hA5);
    push_byte(8'h3C);
    s = st_q[0];
    txif.valid = 1'b0;
    while (cyc < s + 43) tick();
    check("pre-rst count", int'(fifo_count), 1);
    check("pre-rst sout", int'(sout), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async sout", int'(sout), 1);
    check("async count", int'(fifo_count), 0);
    check("async busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    prev_busy = 1'b0;
    trk_bad = 0;
    idle(300);
    check_rx("post-rst");

    // Push on the STOP exit edge: one idle cycle before the next frame.
    push_byte(8'h5A);
    e = st_q[0] + FrameLen;
    txif.valid = 1'b0;
    while (cyc < e - 1) tick();
    push_byte(8'hC3);
    drain();
    check("exit-edge push", (dut_acc_q.size() > 1) ? dut_acc_q[1] : -1, e);
    check("exit-edge start", (rx_s.size() > 1) ? rx_s[1] : -1, e + 1);
    check_rx("exit-edge");

    // Push one edge before STOP exit: no gap.
    push_byte(8'h96);
    e = st_q[0] + FrameLen;
    txif.valid = 1'b0;
    while (cyc < e - 2) tick();
    push_byte(8'h69);
    drain();
    check("pre-exit start", (rx_s.size() > 1) ? rx_s[1] : -1, e);
    check_rx("pre-exit");

    // Random traffic: bursts and gaps of assorted lengths.
    for (int i = 0; i < 40; i++) begin
      idle(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 130)) : 0);
      push_byte(8'($urandom_range(0, 255)));
    end
    drain();
    check_rx("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
